// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames with a one-byte holding register in front of the shifter.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DIV_NUM   = CLK_FREQ / BAUD_RATE
) (
  input  logic       iCLK,
  input  logic       RST_n,
  input  logic [7:0] txd,
  input  logic       TX_START,
  output logic       TX_READY,
  output logic       TX_BUSY,
  output logic       tx,
  output logic       TX_END,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd3
`endif
  } state_t;

  localparam logic [8:0] CNT_MAX = 9'(DIV_NUM - 1);

  state_t     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_full_q, hold_full_d;
  logic       tx_q, tx_d;
  logic       tx_end_q, tx_end_d;
  logic       bit_end;
  logic [2:0] idx_inc;

  assign bit_end = (cnt_q == CNT_MAX);
  assign idx_inc = idx_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    tx_end_d    = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? 9'd0 : cnt_q + 9'd1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          shift_d     = hold_data_q;
          hold_full_d = 1'b0;
          state_d     = START;
          tx_d        = 1'b0;
          cnt_d       = 9'd0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^shift_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_inc;
            tx_d  = shift_q[idx_inc];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          tx_end_d = 1'b1;
          // A waiting byte starts its frame on the very edge the stop bit ends.
          if (hold_full_q) begin
            shift_d     = hold_data_q;
            hold_full_d = 1'b0;
            state_d     = START;
            tx_d        = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Handshake: a byte transfers on any rising edge where TX_START (valid) and
    // TX_READY (ready) are both 1; the source holds txd/TX_START until then.
    // Acceptance needs an empty register, so it never collides with a transfer out.
    if (TX_START && !hold_full_q) begin
      hold_data_d = txd;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      cnt_q       <= 9'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      hold_data_q <= 8'd0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      tx_end_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      tx_end_q    <= tx_end_d;
    end
  end

  assign TX_READY  = !hold_full_q;
  assign TX_BUSY   = (state_q != IDLE) | hold_full_q;
  assign tx        = tx_q;
  assign TX_END    = tx_end_q;
  assign dbg_state = state_q;

endmodule
